// File: rtl/registers_banked.sv
// Banked register file: one modify port, two combinational read ports, zero/carry
// status and a one-deep shadow bank for single-cycle context save/restore.
module registers_banked #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int REG_COUNT      = 8,
    parameter int ZERO_REG       = 0,
    parameter int BYPASS         = 1,
    localparam int SEL_W         = $clog2(REG_COUNT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                op,
    input  logic [SEL_W-1:0]          reg_in_sel,
    input  logic [SEL_W-1:0]          reg_1_out_sel,
    input  logic [SEL_W-1:0]          reg_2_out_sel,
    input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
    output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
    output logic [DATA_BUS_WIDTH-1:0] reg_2_out,
    output logic                      zero_flag,
    output logic                      carry_flag,
    output logic                      shadow_valid,
    output logic                      restore_err
);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_WRITE   = 3'd1,
        OP_INC     = 3'd2,
        OP_DEC     = 3'd3,
        OP_CLEAR   = 3'd4,
        OP_SAVE    = 3'd5,
        OP_RESTORE = 3'd6,
        OP_RSVD    = 3'd7
    } op_t;

    logic [DATA_BUS_WIDTH-1:0] reg_file_reg [REG_COUNT];
    logic [DATA_BUS_WIDTH-1:0] shadow_reg   [REG_COUNT];
    logic                      zero_flag_reg;
    logic                      carry_flag_reg;
    logic                      shadow_valid_reg;
    logic                      restore_err_reg;

    op_t                       op_dec;
    logic [DATA_BUS_WIDTH-1:0] cur_val;
    logic [DATA_BUS_WIDTH-1:0] nxt_val;
    logic                      is_modify;
    logic                      is_incdec;
    logic                      wrap;
    logic                      commit;
    logic                      do_restore;
    logic                      dest_is_zero_reg;

    assign op_dec  = op_t'(op);
    assign cur_val = reg_file_reg[reg_in_sel];

    always_comb begin
        nxt_val   = cur_val;
        is_modify = 1'b0;
        is_incdec = 1'b0;
        wrap      = 1'b0;
        case (op_dec)
            OP_WRITE: begin
                nxt_val   = reg_data_in;
                is_modify = 1'b1;
            end
            OP_INC: begin
                nxt_val   = cur_val + 1'b1;
                is_modify = 1'b1;
                is_incdec = 1'b1;
                wrap      = (cur_val == {DATA_BUS_WIDTH{1'b1}});
            end
            OP_DEC: begin
                nxt_val   = cur_val - 1'b1;
                is_modify = 1'b1;
                is_incdec = 1'b1;
                wrap      = (cur_val == '0);
            end
            OP_CLEAR: begin
                nxt_val   = '0;
                is_modify = 1'b1;
            end
            default: ;
        endcase
    end

    // A hard-wired register 0 swallows modify ops entirely, flags included.
    assign dest_is_zero_reg = (ZERO_REG != 0) && (reg_in_sel == '0);
    assign commit           = is_modify && !dest_is_zero_reg;
    assign do_restore       = (op_dec == OP_RESTORE) && shadow_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            always_ff @(posedge clock) begin
                if (reset) begin
                    reg_file_reg[gi] <= '0;
                    shadow_reg[gi]   <= '0;
                end else begin
                    if (op_dec == OP_SAVE)
                        shadow_reg[gi] <= reg_file_reg[gi];
                    if (do_restore)
                        reg_file_reg[gi] <= ((ZERO_REG != 0) && (gi == 0)) ? '0 : shadow_reg[gi];
                    else if (commit && (reg_in_sel == SEL_W'(gi)))
                        reg_file_reg[gi] <= nxt_val;
                end
            end
        end
    endgenerate

    logic [SEL_W-1:0]          rd_sel  [2];
    logic [DATA_BUS_WIDTH-1:0] rd_data [2];

    assign rd_sel[0] = reg_1_out_sel;
    assign rd_sel[1] = reg_2_out_sel;
    assign reg_1_out = rd_data[0];
    assign reg_2_out = rd_data[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = reg_file_reg[rd_sel[gi]];
                if (BYPASS != 0) begin
                    if (do_restore)
                        rd_data[gi] = shadow_reg[rd_sel[gi]];
                    else if (commit && (rd_sel[gi] == reg_in_sel))
                        rd_data[gi] = nxt_val;
                end
                if ((ZERO_REG != 0) && (rd_sel[gi] == '0))
                    rd_data[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            zero_flag_reg    <= 1'b0;
            carry_flag_reg   <= 1'b0;
            shadow_valid_reg <= 1'b0;
            restore_err_reg  <= 1'b0;
        end else begin
            if (commit) begin
                zero_flag_reg <= (nxt_val == '0);
                if (is_incdec)
                    carry_flag_reg <= wrap;
            end
            if (op_dec == OP_SAVE)
                shadow_valid_reg <= 1'b1;
            else if (do_restore)
                shadow_valid_reg <= 1'b0;
            restore_err_reg <= (op_dec == OP_RESTORE) && !shadow_valid_reg;
        end
    end

    assign zero_flag    = zero_flag_reg;
    assign carry_flag   = carry_flag_reg;
    assign shadow_valid = shadow_valid_reg;
    assign restore_err  = restore_err_reg;

endmodule

// File: tb/tb_registers_banked.sv
// Bench for registers_banked: three parameterisations share one stimulus stream;
// expectations are queued as each op is driven and checked before the next edge.
module tb_registers_banked;

    localparam int W = 8;
    localparam int N = 8;
    localparam int S = 3;

    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, INC = 3'd2, DEC = 3'd3,
                           CLR = 3'd4, SAVE = 3'd5, RST = 3'd6;

    // Signal ids used by the scoreboard
    localparam int A1 = 0, A2 = 1, B1 = 2, B2 = 3, C1 = 4, C2 = 5;
    localparam int AZ = 6, AC = 7, AV = 8, AE = 9, CZ = 10, CC = 11, CV = 12, CE = 13;

    logic         clk = 1'b0;
    logic         srst;
    logic [2:0]   op;
    logic [S-1:0] in_sel, s1, s2;
    logic [W-1:0] din;

    logic [W-1:0] a_r1, a_r2, b_r1, b_r2, c_r1, c_r2;
    logic         a_z, a_c, a_v, a_e;
    logic         b_z, b_c, b_v, b_e;
    logic         c_z, c_c, c_v, c_e;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    registers_banked #(.DATA_BUS_WIDTH(W), .REG_COUNT(N), .ZERO_REG(0), .BYPASS(0)) dut_a (
        .clock(clk), .reset(srst), .op(op), .reg_in_sel(in_sel),
        .reg_1_out_sel(s1), .reg_2_out_sel(s2), .reg_data_in(din),
        .reg_1_out(a_r1), .reg_2_out(a_r2), .zero_flag(a_z), .carry_flag(a_c),
        .shadow_valid(a_v), .restore_err(a_e));

    registers_banked #(.DATA_BUS_WIDTH(W), .REG_COUNT(N), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clock(clk), .reset(srst), .op(op), .reg_in_sel(in_sel),
        .reg_1_out_sel(s1), .reg_2_out_sel(s2), .reg_data_in(din),
        .reg_1_out(b_r1), .reg_2_out(b_r2), .zero_flag(b_z), .carry_flag(b_c),
        .shadow_valid(b_v), .restore_err(b_e));

    registers_banked #(.DATA_BUS_WIDTH(W), .REG_COUNT(N), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clock(clk), .reset(srst), .op(op), .reg_in_sel(in_sel),
        .reg_1_out_sel(s1), .reg_2_out_sel(s2), .reg_data_in(din),
        .reg_1_out(c_r1), .reg_2_out(c_r2), .zero_flag(c_z), .carry_flag(c_c),
        .shadow_valid(c_v), .restore_err(c_e));

    function automatic logic [31:0] sample(int id);
        case (id)
            A1: return 32'(a_r1);
            A2: return 32'(a_r2);
            B1: return 32'(b_r1);
            B2: return 32'(b_r2);
            C1: return 32'(c_r1);
            C2: return 32'(c_r2);
            AZ: return 32'(a_z);
            AC: return 32'(a_c);
            AV: return 32'(a_v);
            AE: return 32'(a_e);
            CZ: return 32'(c_z);
            CC: return 32'(c_c);
            CV: return 32'(c_v);
            CE: return 32'(c_e);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    // Drive one op away from the edge, then drain queued expectations before the edge.
    task automatic step(input logic rst, input logic [2:0] o, input logic [S-1:0] dst,
                        input logic [W-1:0] d, input logic [S-1:0] p1, input logic [S-1:0] p2);
        exp_t e;
        int   n;
        @(negedge clk);
        srst   = rst;
        op     = o;
        in_sel = dst;
        din    = d;
        s1     = p1;
        s2     = p2;
        #1;
        n = exp_q.size();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, sample(e.sig), e.exp);
        end
        $display("op=%0d rst=%0d dst=%0d din=0x%02h sel1=%0d sel2=%0d r1(a/b/c)=%02h/%02h/%02h checks=%0d",
                 o, rst, dst, d, p1, p2, a_r1, b_r1, c_r1, n);
    endtask

    initial begin
        srst = 1'b1; op = NOP; in_sel = '0; din = '0; s1 = '0; s2 = '0;

        step(1, NOP, 0, 8'h00, 0, 0);

        // Reset state, and WRITE r3 = A5 seen before the edge
        expect_val("rst_a_r1", A1, 0);
        expect_val("rst_zero", AZ, 0);
        expect_val("rst_carry", AC, 0);
        expect_val("rst_valid", AV, 0);
        expect_val("rst_err", AE, 0);
        step(0, NOP, 0, 8'h00, 3, 3);
        expect_val("wr_pre_nobyp1", A1, 0);
        expect_val("wr_pre_nobyp2", A2, 0);
        expect_val("wr_pre_byp1", B1, 8'hA5);
        expect_val("wr_pre_byp2", B2, 8'hA5);
        expect_val("wr_pre_c1", C1, 8'hA5);
        step(0, WR, 3, 8'hA5, 3, 3);
        expect_val("wr_post_a1", A1, 8'hA5);
        expect_val("wr_post_a2", A2, 8'hA5);
        expect_val("wr_post_b1", B1, 8'hA5);
        expect_val("wr_post_zero", AZ, 0);
        step(0, NOP, 0, 8'h00, 3, 3);

        // Wrap behaviour on r1
        expect_val("ff_byp", B1, 8'hFF);
        step(0, WR, 1, 8'hFF, 1, 1);
        expect_val("inc_pre_a1", A1, 8'hFF);
        expect_val("inc_byp", B1, 8'h00);
        step(0, INC, 1, 8'h00, 1, 1);
        expect_val("inc_a1", A1, 8'h00);
        expect_val("inc_carry", AC, 1);
        expect_val("inc_zero", AZ, 1);
        expect_val("inc_c_carry", CC, 1);
        expect_val("dec_byp", B1, 8'hFF);
        step(0, DEC, 1, 8'h00, 1, 1);
        expect_val("dec1_a1", A1, 8'hFF);
        expect_val("dec1_carry", AC, 1);
        expect_val("dec1_zero", AZ, 0);
        expect_val("dec2_byp", B1, 8'hFE);
        step(0, DEC, 1, 8'h00, 1, 1);
        expect_val("dec2_a1", A1, 8'hFE);
        expect_val("dec2_carry", AC, 0);
        expect_val("dec2_zero", AZ, 0);
        step(0, NOP, 0, 8'h00, 1, 1);

        // Load r0..r7, r0 write discarded in the zero-register instance
        for (int i = 0; i < N; i++) begin
            expect_val("load_byp", B1, 32'h10 + i);
            expect_val("load_c", C1, (i == 0) ? 32'h0 : 32'h10 + i);
            step(0, WR, S'(i), W'(8'h10 + i), S'(i), S'(i));
        end

        expect_val("save_a1", A1, 8'h12);
        expect_val("save_a2", A2, 8'h15);
        expect_val("save_valid_pre", AV, 0);
        step(0, SAVE, 0, 8'h00, 2, 5);
        expect_val("clr_valid", AV, 1);
        expect_val("clr_c_valid", CV, 1);
        expect_val("clr_byp", B1, 8'h00);
        expect_val("clr_nobyp", A1, 8'h12);
        step(0, CLR, 2, 8'h00, 2, 5);
        expect_val("wr0_zero", AZ, 1);
        expect_val("wr0_c_zero", CZ, 1);
        expect_val("wr0_a1", A1, 8'h10);
        expect_val("wr0_b1", B1, 8'h5A);
        expect_val("wr0_c1", C1, 8'h00);
        expect_val("wr0_a2", A2, 8'h00);
        step(0, WR, 0, 8'h5A, 0, 2);
        expect_val("wr5_a_zero", AZ, 0);
        expect_val("wr5_c_zero_kept", CZ, 1);
        expect_val("wr5_a1", A1, 8'h5A);
        expect_val("wr5_c1", C1, 8'h00);
        expect_val("wr5_b2", B2, 8'h99);
        step(0, WR, 5, 8'h99, 0, 5);
        expect_val("rs_valid_pre", AV, 1);
        expect_val("rs_byp1", B1, 8'h10);
        expect_val("rs_byp2", B2, 8'h15);
        expect_val("rs_nobyp1", A1, 8'h5A);
        expect_val("rs_nobyp2", A2, 8'h99);
        expect_val("rs_c1", C1, 8'h00);
        expect_val("rs_c2", C2, 8'h15);
        step(0, RST, 0, 8'h00, 0, 5);
        expect_val("rs_valid_post", AV, 0);
        expect_val("rs_err", AE, 0);
        for (int i = 0; i < N; i++) begin
            expect_val("rs_read1", A1, 32'h10 + i);
            expect_val("rs_read2", A2, 32'h17 - i);
            expect_val("rs_c_read", C1, (i == 0) ? 32'h0 : 32'h10 + i);
            step(0, NOP, 0, 8'h00, S'(i), S'(N - 1 - i));
        end

        // Invalid RESTORE immediately after reset
        step(1, NOP, 0, 8'h00, 3, 3);
        expect_val("bad_rs_valid", AV, 0);
        step(0, RST, 0, 8'h00, 3, 3);
        expect_val("bad_rs_err", AE, 1);
        expect_val("bad_rs_c_err", CE, 1);
        expect_val("bad_rs_valid2", AV, 0);
        expect_val("bad_rs_a1", A1, 8'h00);
        step(0, NOP, 0, 8'h00, 3, 3);
        expect_val("bad_rs_err_gone", AE, 0);
        step(0, NOP, 0, 8'h00, 3, 3);

        // Reset overriding a WRITE after SAVE discards the shadow
        step(0, WR, 4, 8'h11, 4, 4);
        step(0, SAVE, 0, 8'h00, 4, 4);
        expect_val("ovr_valid_pre", AV, 1);
        step(1, WR, 4, 8'h33, 4, 4);
        expect_val("ovr_valid", AV, 0);
        expect_val("ovr_a1", A1, 8'h00);
        expect_val("ovr_b1", B1, 8'h00);
        step(0, RST, 0, 8'h00, 4, 4);
        expect_val("ovr_err", AE, 1);
        expect_val("ovr_a1_after", A1, 8'h00);
        expect_val("ovr_valid_after", AV, 0);
        step(0, NOP, 0, 8'h00, 4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
